// File: rtl/sdram_req_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM request arbiter: FSM states,
// port IDs and the bit layout of the {rw, addr, data} command record.
package sdram_req_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Command record is packed MSB-first as {rw, addr, data}.
  function automatic int cmd_width(input int addr_n, input int data_n);
    return addr_n + data_n + 1;
  endfunction

  function automatic int cmd_addr_lsb(input int data_n);
    return data_n;
  endfunction

  function automatic int cmd_rw_bit(input int addr_n, input int data_n);
    return addr_n + data_n;
  endfunction

endpackage

// File: rtl/sdram_req_arbiter_tag_fifo.sv
// Read-tag queue: 1-bit port IDs in issue order, DEPTH entries, with
// wrap-around pointers one bit wider than the index so full = count MSB.
module sdram_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic empty,
  output logic full
);

  logic [PTR_N:0]   wr_ptr_r;
  logic [PTR_N:0]   rd_ptr_r;
  logic [PTR_N:0]   count_s;
  logic [DEPTH-1:0] mem_r;

  assign count_s  = wr_ptr_r - rd_ptr_r;
  assign empty    = (count_s == {(PTR_N+1){1'b0}});
  assign full     = count_s[PTR_N];
  assign head_tag = mem_r[rd_ptr_r[PTR_N-1:0]];

  // Pointer and storage update; push and pop may both land in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(PTR_N+1){1'b0}};
      rd_ptr_r <= {(PTR_N+1){1'b0}};
      mem_r    <= {DEPTH{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(PTR_N+1){1'b0}};
      rd_ptr_r <= {(PTR_N+1){1'b0}};
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[PTR_N-1:0]] <= push_tag;
        wr_ptr_r <= wr_ptr_r + {{PTR_N{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_N{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-port SDRAM command arbiter with in-order read-data routing.
// Define SDRAM_ARB_FIXED_PRIORITY_EN for fixed port-0 priority instead of round-robin.
module sdram_req_arbiter
  import sdram_req_arbiter_pkg::*;
#(
  parameter int ADDR_N    = 25,
  parameter int DATA_N    = 16,
  parameter int TAG_DEPTH = 4,
  parameter int TAG_D_N   = 2
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iREMOVE,
  input  logic              iREQ0_VALID,
  output logic              oREQ0_BUSY,
  input  logic              iREQ0_RW,
  input  logic [ADDR_N-1:0] iREQ0_ADDR,
  input  logic [DATA_N-1:0] iREQ0_DATA,
  output logic              oREQ0_VALID,
  output logic [DATA_N-1:0] oREQ0_DATA,
  input  logic              iREQ1_VALID,
  output logic              oREQ1_BUSY,
  input  logic              iREQ1_RW,
  input  logic [ADDR_N-1:0] iREQ1_ADDR,
  input  logic [DATA_N-1:0] iREQ1_DATA,
  output logic              oREQ1_VALID,
  output logic [DATA_N-1:0] oREQ1_DATA,
  output logic              oSDRAM_VALID,
  input  logic              iSDRAM_BUSY,
  output logic              oSDRAM_RW,
  output logic [ADDR_N-1:0] oSDRAM_ADDR,
  output logic [DATA_N-1:0] oSDRAM_DATA,
  input  logic              iSDRAM_RD_VALID,
  input  logic [DATA_N-1:0] iSDRAM_RD_DATA,
  output logic              oERR_ORPHAN
);

  localparam int CMD_N    = cmd_width(ADDR_N, DATA_N);
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_N);
  localparam int RW_BIT   = cmd_rw_bit(ADDR_N, DATA_N);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic [CMD_N-1:0]  cmd_r;
  logic [CMD_N-1:0]  cmd_in_s;
  logic              grant0_s;
  logic              grant1_s;
  logic              busy0_s;
  logic              busy1_s;
  logic              xfer0_s;
  logic              xfer1_s;
  logic              xfer_s;
  logic              push_s;
  logic              pop_s;
  logic              head_tag_s;
  logic              empty_s;
  logic              full_s;
  logic              ret0_valid_r;
  logic              ret1_valid_r;
  logic [DATA_N-1:0] ret0_data_r;
  logic [DATA_N-1:0] ret1_data_r;
  logic              orphan_r;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
  logic              last_r;
`endif

  // Grant decision; only meaningful while idle.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (iREQ0_VALID && !iREQ1_VALID) begin
        grant0_s = 1'b1;
      end else if (!iREQ0_VALID && iREQ1_VALID) begin
        grant1_s = 1'b1;
      end else if (iREQ0_VALID && iREQ1_VALID) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        grant0_s = 1'b1;
`else
        if (last_r == PORT1) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
`endif
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // A full tag queue blocks writes too, keeping the rule uniform per port.
  assign busy0_s    = !(grant0_s && !full_s);
  assign busy1_s    = !(grant1_s && !full_s);
  assign oREQ0_BUSY = busy0_s;
  assign oREQ1_BUSY = busy1_s;
  assign xfer0_s    = iREQ0_VALID && !busy0_s;
  assign xfer1_s    = iREQ1_VALID && !busy1_s;
  assign xfer_s     = xfer0_s || xfer1_s;
  assign push_s     = xfer_s && !cmd_in_s[RW_BIT];
  assign pop_s      = iSDRAM_RD_VALID && !empty_s;

  // Command record selected from the transferring port.
  always_comb begin
    cmd_in_s = {CMD_N{1'b0}};
    if (xfer1_s) begin
      cmd_in_s = {iREQ1_RW, iREQ1_ADDR, iREQ1_DATA};
    end else begin
      cmd_in_s = {iREQ0_RW, iREQ0_ADDR, iREQ0_DATA};
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!iSDRAM_BUSY) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register; flush drops any in-flight command.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state_r <= ST_IDLE;
    end else if (iREMOVE) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Command register holds fields stable until the controller accepts.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      cmd_r <= {CMD_N{1'b0}};
    end else if (xfer_s) begin
      cmd_r <= cmd_in_s;
    end
  end

`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
  // Round-robin pointer; reset to port 1 so port 0 takes the first tie.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      last_r <= PORT1;
    end else if (xfer_s) begin
      last_r <= xfer1_s ? PORT1 : PORT0;
    end
  end
`endif

  // Read-data return routing by head tag.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      ret0_valid_r <= 1'b0;
      ret1_valid_r <= 1'b0;
      ret0_data_r  <= {DATA_N{1'b0}};
      ret1_data_r  <= {DATA_N{1'b0}};
    end else if (iREMOVE) begin
      ret0_valid_r <= 1'b0;
      ret1_valid_r <= 1'b0;
    end else begin
      ret0_valid_r <= pop_s && (head_tag_s == PORT0);
      ret1_valid_r <= pop_s && (head_tag_s == PORT1);
      if (pop_s && (head_tag_s == PORT0)) begin
        ret0_data_r <= iSDRAM_RD_DATA;
      end
      if (pop_s && (head_tag_s == PORT1)) begin
        ret1_data_r <= iSDRAM_RD_DATA;
      end
    end
  end

  // Sticky orphan flag; survives flush, cleared only by reset.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      orphan_r <= 1'b0;
    end else if (iSDRAM_RD_VALID && empty_s) begin
      orphan_r <= 1'b1;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .PTR_N (TAG_D_N)
  ) u_tag_fifo (
    .clk      (iCLOCK),
    .rst      (iRESET),
    .flush    (iREMOVE),
    .push     (push_s),
    .push_tag (xfer1_s),
    .pop      (pop_s),
    .head_tag (head_tag_s),
    .empty    (empty_s),
    .full     (full_s)
  );

  assign oSDRAM_VALID = (state_r == ST_ISSUE);
  assign oSDRAM_RW    = cmd_r[RW_BIT];
  assign oSDRAM_ADDR  = cmd_r[ADDR_LSB +: ADDR_N];
  assign oSDRAM_DATA  = cmd_r[DATA_N-1:0];
  assign oREQ0_VALID  = ret0_valid_r;
  assign oREQ1_VALID  = ret1_valid_r;
  assign oREQ0_DATA   = ret0_data_r;
  assign oREQ1_DATA   = ret1_data_r;
  assign oERR_ORPHAN  = orphan_r;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: expected commands/returns are queued
// at stimulus time and a negedge monitor pops and compares them.
module tb_sdram_req_arbiter;

  logic        iCLOCK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iREMOVE = 1'b0;
  logic        iREQ0_VALID = 1'b0, iREQ1_VALID = 1'b0;
  logic        oREQ0_BUSY, oREQ1_BUSY;
  logic        iREQ0_RW = 1'b0, iREQ1_RW = 1'b0;
  logic [24:0] iREQ0_ADDR = 25'd0, iREQ1_ADDR = 25'd0;
  logic [15:0] iREQ0_DATA = 16'd0, iREQ1_DATA = 16'd0;
  logic        oREQ0_VALID, oREQ1_VALID;
  logic [15:0] oREQ0_DATA, oREQ1_DATA;
  logic        oSDRAM_VALID;
  logic        iSDRAM_BUSY = 1'b0;
  logic        oSDRAM_RW;
  logic [24:0] oSDRAM_ADDR;
  logic [15:0] oSDRAM_DATA;
  logic        iSDRAM_RD_VALID = 1'b0;
  logic [15:0] iSDRAM_RD_DATA = 16'd0;
  logic        oERR_ORPHAN;

  int n_cmp = 0;
  int n_fail = 0;
  logic [41:0] exp_cmd[$];
  logic [16:0] exp_ret[$];
  logic        tag_model[$];

  sdram_req_arbiter dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iREMOVE(iREMOVE),
    .iREQ0_VALID(iREQ0_VALID), .oREQ0_BUSY(oREQ0_BUSY), .iREQ0_RW(iREQ0_RW),
    .iREQ0_ADDR(iREQ0_ADDR), .iREQ0_DATA(iREQ0_DATA),
    .oREQ0_VALID(oREQ0_VALID), .oREQ0_DATA(oREQ0_DATA),
    .iREQ1_VALID(iREQ1_VALID), .oREQ1_BUSY(oREQ1_BUSY), .iREQ1_RW(iREQ1_RW),
    .iREQ1_ADDR(iREQ1_ADDR), .iREQ1_DATA(iREQ1_DATA),
    .oREQ1_VALID(oREQ1_VALID), .oREQ1_DATA(oREQ1_DATA),
    .oSDRAM_VALID(oSDRAM_VALID), .iSDRAM_BUSY(iSDRAM_BUSY),
    .oSDRAM_RW(oSDRAM_RW), .oSDRAM_ADDR(oSDRAM_ADDR), .oSDRAM_DATA(oSDRAM_DATA),
    .iSDRAM_RD_VALID(iSDRAM_RD_VALID), .iSDRAM_RD_DATA(iSDRAM_RD_DATA),
    .oERR_ORPHAN(oERR_ORPHAN)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted command and every return strobe is scored.
  always @(negedge iCLOCK) begin
    if (oSDRAM_VALID && !iSDRAM_BUSY) begin
      if (exp_cmd.size() == 0) check("cmd_unexpected", {oSDRAM_RW, oSDRAM_ADDR, oSDRAM_DATA}, 64'd0);
      else check("cmd", {oSDRAM_RW, oSDRAM_ADDR, oSDRAM_DATA}, exp_cmd.pop_front());
    end
    if (oREQ0_VALID && oREQ1_VALID) begin
      check("ret_both_strobes", {oREQ1_VALID, oREQ0_VALID}, 64'd1);
    end else if (oREQ0_VALID || oREQ1_VALID) begin
      if (exp_ret.size() == 0) check("ret_unexpected", {oREQ1_VALID, oREQ0_VALID}, 64'd0);
      else check("ret", {oREQ1_VALID, (oREQ1_VALID ? oREQ1_DATA : oREQ0_DATA)}, exp_ret.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge iCLOCK);
    #1;
  endtask

  task automatic do_reset();
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0; iRESET = 1'b1;
    step(1);
    iRESET = 1'b0;
    exp_cmd.delete(); exp_ret.delete(); tag_model.delete();
  endtask

  task automatic pulse_remove();
    iREMOVE = 1'b1;
    step(1);
    iREMOVE = 1'b0;
    tag_model.delete();
  endtask

  // Present one command on a port until it transfers; record expectations.
  task automatic send(input logic port, input logic rw, input logic [24:0] a, input logic [15:0] d);
    int g = 0;
    bit done = 0;
    if (port) begin iREQ1_VALID = 1'b1; iREQ1_RW = rw; iREQ1_ADDR = a; iREQ1_DATA = d; end
    else      begin iREQ0_VALID = 1'b1; iREQ0_RW = rw; iREQ0_ADDR = a; iREQ0_DATA = d; end
    while (!done && g < 50) begin
      @(negedge iCLOCK);
      if (port ? !oREQ1_BUSY : !oREQ0_BUSY) begin
        done = 1;
        exp_cmd.push_back({rw, a, d});
        if (!rw) tag_model.push_back(port);
      end
      step(1);
      g++;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
  endtask

  task automatic rd_return(input logic [15:0] d);
    iSDRAM_RD_VALID = 1'b1; iSDRAM_RD_DATA = d;
    if (tag_model.size() != 0) exp_ret.push_back({tag_model.pop_front(), d});
    step(1);
    iSDRAM_RD_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while ((exp_cmd.size() != 0 || exp_ret.size() != 0) && g < 100) begin step(1); g++; end
    check({name, "_cmd_left"}, exp_cmd.size(), 64'd0);
    check({name, "_ret_left"}, exp_ret.size(), 64'd0);
  endtask

  // Both ports request writes continuously until six transfers happen.
  task automatic both_six();
    int i0 = 0, i1 = 0, total = 0, g = 0;
    bit t0, t1;
    for (int i = 0; i < 6; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
      exp_cmd.push_back({1'b1, 25'h100 + 25'(i), 16'hA000 + 16'(i)});
`else
      if (i % 2 == 0) exp_cmd.push_back({1'b1, 25'h100 + 25'(i/2), 16'hA000 + 16'(i/2)});
      else            exp_cmd.push_back({1'b1, 25'h200 + 25'(i/2), 16'hB000 + 16'(i/2)});
`endif
    end
    iREQ0_RW = 1'b1; iREQ1_RW = 1'b1;
    iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1;
    while (total < 6 && g < 200) begin
      iREQ0_ADDR = 25'h100 + 25'(i0); iREQ0_DATA = 16'hA000 + 16'(i0);
      iREQ1_ADDR = 25'h200 + 25'(i1); iREQ1_DATA = 16'hB000 + 16'(i1);
      @(negedge iCLOCK);
      t0 = !oREQ0_BUSY; t1 = !oREQ1_BUSY;
      if (t0) i0++;
      if (t1) i1++;
      total = total + int'(t0) + int'(t1);
      step(1);
      g++;
    end
    if (total < 6) check("both_six_timeout", total, 64'd6);
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    iRESET = 1'b0;
    @(negedge iCLOCK);
    check("rst_sdram_valid", oSDRAM_VALID, 64'd0);
    check("rst_sdram_fields", {oSDRAM_RW, oSDRAM_ADDR, oSDRAM_DATA}, 64'd0);
    check("rst_ret_valid", {oREQ1_VALID, oREQ0_VALID}, 64'd0);
    check("rst_ret_data", {oREQ1_DATA, oREQ0_DATA}, 64'd0);
    check("rst_orphan", oERR_ORPHAN, 64'd0);
    check("rst_busy_idle", {oREQ1_BUSY, oREQ0_BUSY}, 64'd3);
    step(1);

    // Single read on port 0, data returned to port 0.
    send(1'b0, 1'b0, 25'h10, 16'h0);
    @(negedge iCLOCK);
    check("rd_issue_valid", oSDRAM_VALID, 64'd1);
    check("rd_issue_addr", {oSDRAM_RW, oSDRAM_ADDR}, 64'h10);
    step(1);
    rd_return(16'hBEEF);
    @(negedge iCLOCK);
    check("rd_ret0_valid", {oREQ1_VALID, oREQ0_VALID}, 64'd1);
    check("rd_ret0_data", oREQ0_DATA, 64'hBEEF);
    step(1);
    drain("single_rd");

    // Controller stalls five cycles: fields hold, both ports blocked.
    iSDRAM_BUSY = 1'b1;
    send(1'b1, 1'b1, 25'h55, 16'h1234);
    iREQ0_VALID = 1'b1; iREQ0_RW = 1'b1; iREQ0_ADDR = 25'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLOCK);
      check("stall_valid", oSDRAM_VALID, 64'd1);
      check("stall_fields", {oSDRAM_RW, oSDRAM_ADDR, oSDRAM_DATA}, {1'b1, 25'h55, 16'h1234});
      check("stall_busy", {oREQ1_BUSY, oREQ0_BUSY}, 64'd3);
    end
    step(1);
    iREQ0_VALID = 1'b0; iSDRAM_BUSY = 1'b0;
    @(negedge iCLOCK);
    check("stall_accept_c6", oSDRAM_VALID, 64'd1);
    step(1);
    @(negedge iCLOCK);
    check("stall_done", oSDRAM_VALID, 64'd0);
    step(1);
    drain("stall");

    // Continuous contention on both ports.
    do_reset();
    both_six();
    drain("contention");

    // Four outstanding reads fill the tag queue.
    do_reset();
    send(1'b0, 1'b0, 25'h20, 16'h0);
    send(1'b1, 1'b0, 25'h21, 16'h0);
    send(1'b1, 1'b0, 25'h22, 16'h0);
    send(1'b0, 1'b0, 25'h23, 16'h0);
    step(2);
    iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1; iREQ0_RW = 1'b0; iREQ1_RW = 1'b0;
    @(negedge iCLOCK);
    check("full_busy", {oREQ1_BUSY, oREQ0_BUSY}, 64'd3);
    step(1);
    iSDRAM_RD_VALID = 1'b1; iSDRAM_RD_DATA = 16'h1;
    exp_ret.push_back({tag_model.pop_front(), 16'h1});
    @(negedge iCLOCK);
    check("full_pop_busy", {oREQ1_BUSY, oREQ0_BUSY}, 64'd3);
    step(1);
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
    rd_return(16'h2);
    rd_return(16'h3);
    rd_return(16'h4);
    step(1);
    drain("tags");

    // Flush while a command is stalled drops it.
    iSDRAM_BUSY = 1'b1;
    send(1'b1, 1'b1, 25'h40, 16'h5);
    pulse_remove();
    exp_cmd.delete();
    @(negedge iCLOCK);
    check("remove_valid", oSDRAM_VALID, 64'd0);
    step(1);
    iSDRAM_BUSY = 1'b0;

    // Flushed read tag makes later data an orphan.
    send(1'b0, 1'b0, 25'h30, 16'h0);
    step(2);
    pulse_remove();
    drain("pre_orphan");
    rd_return(16'hDEAD);
    @(negedge iCLOCK);
    check("orphan_no_strobe", {oREQ1_VALID, oREQ0_VALID}, 64'd0);
    check("orphan_set", oERR_ORPHAN, 64'd1);
    step(1);
    pulse_remove();
    @(negedge iCLOCK);
    check("orphan_hold_remove", oERR_ORPHAN, 64'd1);
    step(1);
    do_reset();
    @(negedge iCLOCK);
    check("orphan_clr_reset", oERR_ORPHAN, 64'd0);
    step(1);

    // Reset mid-issue abandons the command and the round-robin history.
    send(1'b1, 1'b0, 25'h50, 16'h0);
    step(2);
    drain("pre_reset_issue");
    iSDRAM_BUSY = 1'b1;
    send(1'b0, 1'b1, 25'h51, 16'h9);
    do_reset();
    @(negedge iCLOCK);
    check("rst_issue_valid", oSDRAM_VALID, 64'd0);
    step(1);
    iSDRAM_BUSY = 1'b0;
    iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1;
    @(negedge iCLOCK);
    check("rst_tie_port0", {oREQ1_BUSY, oREQ0_BUSY}, 64'd2);
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
    step(1);
    rd_return(16'h77);
    @(negedge iCLOCK);
    check("rst_queue_empty", oERR_ORPHAN, 64'd1);
    check("rst_no_strobe", {oREQ1_VALID, oREQ0_VALID}, 64'd0);
    step(1);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
